// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC / fetch-sequencing stage.
package pc_fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_EXIT_CODE = 32'd10;

  // Fetch sequencer state encoding
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // Decoder control outputs that steer the next PC
  typedef struct packed {
    logic beq;
    logic bne;
    logic j;
    logic jal;
    logic jr;
    logic syscall;
  } ctrl_t;

  // Sign-extended word offset of a branch immediate, in bytes
  function automatic logic [XLEN-1:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Combinational next-PC resolution: syscall > jr > j/jal > taken branch > pc+4.
module pc_fetch_unit_next_pc_sel
  import pc_fetch_unit_pkg::*;
(
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [25:0]     target,
  input  logic [29:0]     rs_word,
  input  logic            equal,
  input  ctrl_t           ctrl,
  output logic [XLEN-1:0] next_pc,
  output logic            br_taken,
  output logic            jmp_taken
);

  logic br_cond;

  assign br_cond = (ctrl.beq & equal) | (ctrl.bne & ~equal);

  // Priority select of the next PC and the taken flags for the stats counters
  always_comb begin
    next_pc   = pc_plus4;
    br_taken  = 1'b0;
    jmp_taken = 1'b0;
    if (ctrl.syscall) begin
      next_pc = pc_plus4;
    end else if (ctrl.jr) begin
      next_pc   = {rs_word, 2'b00};
      jmp_taken = 1'b1;
    end else if (ctrl.j | ctrl.jal) begin
      next_pc   = {pc_plus4[31:28], target, 2'b00};
      jmp_taken = 1'b1;
    end else if (br_cond) begin
      next_pc  = pc_plus4 + branch_offset(target[15:0]);
      br_taken = 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer: next-PC update, syscall halt/resume, display latch.
// Optional statistics counters are built when PC_STATS_EN is defined.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0]  RESET_PC  = 32'h0000_0000,
  parameter int unsigned  IMEM_AW   = 10,
  parameter logic [31:0]  EXIT_CODE = DEFAULT_EXIT_CODE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic [31:0]        instr,
  input  logic [31:0]        rs_data,
  input  logic               equal,
  input  logic               beq,
  input  logic               bne,
  input  logic               j,
  input  logic               jal,
  input  logic               jr,
  input  logic               syscall,
  input  logic [31:0]        v0,
  input  logic [31:0]        a0,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               run_en,
  output logic               halted,
  output logic [31:0]        disp_data,
  output logic               disp_valid,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        jump_cnt,
  output logic [31:0]        btaken_cnt
);

  state_e      state, state_nx;
  logic        go_q;
  logic [31:0] pc_nx;
  logic [31:0] disp_data_nx;
  logic        disp_valid_nx;
  logic [31:0] sel_pc;
  logic        br_taken;
  logic        jmp_taken;
  ctrl_t       ctrl;

  // Opcode/funct bits and the low jr target bits play no part here
  logic unused_bits;
  assign unused_bits = &{1'b0, instr[31:26], rs_data[1:0]};

  assign ctrl      = {beq, bne, j, jal, jr, syscall};
  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc[IMEM_AW+1:2];
  assign run_en    = (state == ST_RUN);
  assign halted    = (state == ST_HALT);

  pc_fetch_unit_next_pc_sel u_next_pc_sel (
    .pc_plus4  (pc_plus4),
    .target    (instr[25:0]),
    .rs_word   (rs_data[31:2]),
    .equal     (equal),
    .ctrl      (ctrl),
    .next_pc   (sel_pc),
    .br_taken  (br_taken),
    .jmp_taken (jmp_taken)
  );

  // State, PC, go edge detector and display registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RUN;
      go_q       <= 1'b0;
      pc         <= RESET_PC;
      disp_data  <= 32'd0;
      disp_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      go_q       <= go;
      pc         <= pc_nx;
      disp_data  <= disp_data_nx;
      disp_valid <= disp_valid_nx;
    end
  end

  // Next state, next PC and display update; HALT ignores all control inputs
  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    disp_data_nx  = disp_data;
    disp_valid_nx = 1'b0;
    unique case (state)
      ST_RUN: begin
        pc_nx = sel_pc;
        if (syscall) begin
          if (v0 == EXIT_CODE) begin
            state_nx = ST_HALT;
          end else begin
            disp_data_nx  = a0;
            disp_valid_nx = 1'b1;
          end
        end
      end
      ST_HALT: begin
        if (go & ~go_q) begin
          state_nx = ST_RUN;
        end
      end
      default: state_nx = ST_RUN;
    endcase
  end

`ifdef PC_STATS_EN
  logic [31:0] cycle_q;
  logic [31:0] jump_q;
  logic [31:0] btaken_q;

  // Statistics counters, advancing only while running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q  <= 32'd0;
      jump_q   <= 32'd0;
      btaken_q <= 32'd0;
    end else if (state == ST_RUN) begin
      cycle_q <= cycle_q + 32'd1;
      if (jmp_taken) jump_q   <= jump_q + 32'd1;
      if (br_taken)  btaken_q <= btaken_q + 32'd1;
    end
  end

  assign cycle_cnt  = cycle_q;
  assign jump_cnt   = jump_q;
  assign btaken_cnt = btaken_q;
`else
  logic unused_stats;
  assign unused_stats = &{1'b0, br_taken, jmp_taken};

  assign cycle_cnt  = 32'd0;
  assign jump_cnt   = 32'd0;
  assign btaken_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them and checks every display pulse.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, go, equal;
  logic        beq, bne, j, jal, jr, syscall;
  logic [31:0] instr, rs_data, v0, a0;
  logic [31:0] pc, pc_plus4, disp_data, cycle_cnt, jump_cnt, btaken_cnt;
  logic [9:0]  imem_addr;
  logic        run_en, halted, disp_valid;

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_BEQ  = 6'b100000;
  localparam logic [5:0] C_BNE  = 6'b010000;
  localparam logic [5:0] C_J    = 6'b001000;
  localparam logic [5:0] C_JAL  = 6'b000100;
  localparam logic [5:0] C_JR   = 6'b000010;
  localparam logic [5:0] C_SYS  = 6'b000001;

`ifdef PC_STATS_EN
  localparam logic [31:0] E_CC3 = 32'd3, E_CC5 = 32'd5, E_ONE = 32'd1;
`else
  localparam logic [31:0] E_CC3 = 32'd0, E_CC5 = 32'd0, E_ONE = 32'd0;
`endif

  typedef enum int {S_PC, S_PLUS4, S_IMEM, S_RUN, S_HALT, S_DDATA, S_DVALID,
                    S_CC, S_JC, S_BC} sig_e;
  typedef struct {
    int          at;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] disp_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  pc_fetch_unit dut (
    .clk(clk), .rst(rst), .go(go), .instr(instr), .rs_data(rs_data), .equal(equal),
    .beq(beq), .bne(bne), .j(j), .jal(jal), .jr(jr), .syscall(syscall),
    .v0(v0), .a0(a0), .pc(pc), .pc_plus4(pc_plus4), .imem_addr(imem_addr),
    .run_en(run_en), .halted(halted), .disp_data(disp_data), .disp_valid(disp_valid),
    .cycle_cnt(cycle_cnt), .jump_cnt(jump_cnt), .btaken_cnt(btaken_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input sig_e s);
    case (s)
      S_PC:     return pc;
      S_PLUS4:  return pc_plus4;
      S_IMEM:   return 32'(imem_addr);
      S_RUN:    return 32'(run_en);
      S_HALT:   return 32'(halted);
      S_DDATA:  return disp_data;
      S_DVALID: return 32'(disp_valid);
      S_CC:     return cycle_cnt;
      S_JC:     return jump_cnt;
      default:  return btaken_cnt;
    endcase
  endfunction

  function automatic string sig_name(input sig_e s);
    case (s)
      S_PC:     return "pc";
      S_PLUS4:  return "pc_plus4";
      S_IMEM:   return "imem_addr";
      S_RUN:    return "run_en";
      S_HALT:   return "halted";
      S_DDATA:  return "disp_data";
      S_DVALID: return "disp_valid";
      S_CC:     return "cycle_cnt";
      S_JC:     return "jump_cnt";
      default:  return "btaken_cnt";
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle, and every display pulse
  exp_t        mon_e;
  logic [31:0] mon_act;
  logic [31:0] mon_d;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      mon_e   = exp_q.pop_front();
      mon_act = actual(mon_e.sig);
      n_checks++;
      if (mon_act !== mon_e.val) begin
        n_errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                 sig_name(mon_e.sig), mon_act, mon_e.val, cyc);
      end
    end
    if (disp_valid === 1'b1) begin
      n_checks++;
      if (disp_q.size() == 0) begin
        n_errors++;
        $display("FAIL disp_pulse: got unexpected pulse data 0x%08h expected no pulse (cycle %0d)",
                 disp_data, cyc);
      end else begin
        mon_d = disp_q.pop_front();
        if (disp_data !== mon_d) begin
          n_errors++;
          $display("FAIL disp_pulse: got 0x%08h expected 0x%08h (cycle %0d)", disp_data, mon_d, cyc);
        end
      end
    end
  end

  // One stimulus slot: inputs change just after the falling edge
  task automatic drive(input logic [5:0] c = C_NONE, input logic [31:0] ins = 32'd0,
                       input logic eq = 1'b0, input logic [31:0] rs = 32'd0,
                       input logic [31:0] v = 32'd0, input logic [31:0] a = 32'd0);
    @(negedge clk);
    #1;
    {beq, bne, j, jal, jr, syscall} = c;
    instr = ins; equal = eq; rs_data = rs; v0 = v; a0 = a;
  endtask

  // Expectation for the state after the coming rising edge
  task automatic expect_at(input sig_e s, input logic [31:0] v);
    exp_t e;
    e.at  = cyc + 1;
    e.sig = s;
    e.val = v;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; go = 1'b0;
    {beq, bne, j, jal, jr, syscall} = C_NONE;
    instr = 32'd0; equal = 1'b0; rs_data = 32'd0; v0 = 32'd0; a0 = 32'd0;

    // Reset state and sequential fetch
    drive(); rst = 1'b1;
    expect_at(S_PC, 32'h0); expect_at(S_RUN, 32'd1); expect_at(S_HALT, 32'd0);
    expect_at(S_DDATA, 32'h0); expect_at(S_DVALID, 32'd0); expect_at(S_CC, 32'd0);
    drive(); rst = 1'b0; expect_at(S_PC, 32'h4); expect_at(S_IMEM, 32'd1);
    drive(); expect_at(S_PC, 32'h8); expect_at(S_IMEM, 32'd2);
    drive(); expect_at(S_PC, 32'hC); expect_at(S_IMEM, 32'd3);
    expect_at(S_PLUS4, 32'h10); expect_at(S_RUN, 32'd1);

    // Branches around pc=0x20
    drive(C_J, 32'h0800_0008);           expect_at(S_PC, 32'h20);
    drive(C_BEQ, 32'h1085_FFFE, 1'b1);   expect_at(S_PC, 32'h1C);
    drive(C_J, 32'h0800_0008);           expect_at(S_PC, 32'h20);
    drive(C_BEQ, 32'h1085_FFFE, 1'b0);   expect_at(S_PC, 32'h24);
    drive(C_J, 32'h0800_0008);           expect_at(S_PC, 32'h20);
    drive(C_BNE, 32'h1485_FFFE, 1'b0);   expect_at(S_PC, 32'h1C);
    drive(C_J, 32'h0800_0008);           expect_at(S_PC, 32'h20);
    drive(C_BNE, 32'h1485_FFFE, 1'b1);   expect_at(S_PC, 32'h24);
    drive(C_BEQ, 32'h1085_0003, 1'b1);   expect_at(S_PC, 32'h34);

    // Modulo wrap at the top of the address space
    drive(C_JR, 32'd0, 1'b0, 32'hFFFF_FFFF); expect_at(S_PC, 32'hFFFF_FFFC);
    drive();                                 expect_at(S_PC, 32'h0);

    // Jumps
    drive(C_JR, 32'd0, 1'b0, 32'h3000_0010); expect_at(S_PC, 32'h3000_0010);
    drive(C_J, 32'h0800_0040);               expect_at(S_PC, 32'h3000_0100);
    drive(C_JR, 32'd0, 1'b0, 32'h0000_0087); expect_at(S_PC, 32'h84);

    // Display syscall beats jr; single pulse, then back-to-back pulses
    drive(C_SYS | C_JR, 32'd0, 1'b0, 32'h500, 32'd34, 32'h1234);
    disp_q.push_back(32'h1234);
    expect_at(S_PC, 32'h88); expect_at(S_DVALID, 32'd1); expect_at(S_DDATA, 32'h1234);
    drive(); expect_at(S_PC, 32'h8C); expect_at(S_DVALID, 32'd0); expect_at(S_DDATA, 32'h1234);
    drive(C_JR | C_J, 32'h0800_0040, 1'b0, 32'h200); expect_at(S_PC, 32'h200);
    drive(C_SYS, 32'd0, 1'b0, 32'd0, 32'd34, 32'hA); disp_q.push_back(32'hA);
    expect_at(S_PC, 32'h204); expect_at(S_DVALID, 32'd1);
    drive(C_SYS, 32'd0, 1'b0, 32'd0, 32'd7, 32'hB); disp_q.push_back(32'hB);
    expect_at(S_PC, 32'h208); expect_at(S_DVALID, 32'd1); expect_at(S_DDATA, 32'hB);
    drive(); expect_at(S_DVALID, 32'd0); expect_at(S_DDATA, 32'hB);

    // Exit syscall with a simultaneous go edge, held halt, resume, reset mid-halt
    drive(C_JR, 32'd0, 1'b0, 32'h40); expect_at(S_PC, 32'h40);
    drive(C_SYS, 32'd0, 1'b0, 32'd0, 32'd10, 32'hDEAD); go = 1'b1;
    expect_at(S_PC, 32'h44); expect_at(S_HALT, 32'd1); expect_at(S_RUN, 32'd0);
    expect_at(S_DVALID, 32'd0);
    for (int i = 0; i < 10; i++) begin
      drive((i % 2 == 0) ? (C_SYS | C_J) : C_BEQ, 32'h0800_0040, 1'b1, 32'h300,
            32'd34, 32'h5555);
      go = 1'b1;
      expect_at(S_PC, 32'h44); expect_at(S_HALT, 32'd1); expect_at(S_DDATA, 32'hB);
    end
    drive(); go = 1'b0; expect_at(S_PC, 32'h44); expect_at(S_HALT, 32'd1);
    drive(); go = 1'b1; expect_at(S_PC, 32'h44); expect_at(S_HALT, 32'd0); expect_at(S_RUN, 32'd1);
    drive(); go = 1'b1; expect_at(S_PC, 32'h48);
    drive(C_SYS, 32'd0, 1'b0, 32'd0, 32'd10); expect_at(S_PC, 32'h4C); expect_at(S_HALT, 32'd1);
    drive(); go = 1'b0; rst = 1'b1;
    expect_at(S_PC, 32'h0); expect_at(S_HALT, 32'd0); expect_at(S_RUN, 32'd1);
    expect_at(S_DDATA, 32'h0); expect_at(S_CC, 32'd0); expect_at(S_JC, 32'd0);

    // Statistics: 5 running cycles with one jal and one taken bne, then frozen
    drive(); rst = 1'b0; expect_at(S_PC, 32'h4);
    drive(C_JAL, 32'h0C00_0010);       expect_at(S_PC, 32'h40);
    drive(C_BNE, 32'h1485_0002, 1'b0); expect_at(S_PC, 32'h4C);
    expect_at(S_CC, E_CC3); expect_at(S_JC, E_ONE); expect_at(S_BC, E_ONE);
    drive();                           expect_at(S_PC, 32'h50);
    drive(C_SYS, 32'd0, 1'b0, 32'd0, 32'd10); expect_at(S_PC, 32'h54); expect_at(S_HALT, 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(C_J | C_BEQ, 32'h0800_0040, 1'b1);
      expect_at(S_PC, 32'h54);
      expect_at(S_CC, E_CC5); expect_at(S_JC, E_ONE); expect_at(S_BC, E_ONE);
    end

    drive(); drive();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain_expect: got %0d pending expected 0", exp_q.size());
    end
    n_checks++;
    if (disp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain_disp: got %0d missing pulses expected 0", disp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
